// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 encodings and the load/store bridge state type shared by the
// bridge and anything that needs to decode its bus fields.
package axi_pkg;

    // Burst type encodings carried on awburst/arburst
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    // Response encodings carried on bresp/rresp; bit 1 set means an error
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    // Normal non-cacheable bufferable memory, unprivileged secure data access
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

    // Bridge sequencing: request accept, read address/data, write address+data, write response, core response
    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WR,
        B,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/axi_lsu_master.sv
// axi_lsu_master: turns one core load/store request into a single-beat AXI4
// transaction and returns one registered response. Only one transaction is
// ever in flight, so AXI IDs on the return channels are never inspected.
module axi_lsu_master
    import axi_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter int          ID_WIDTH   = 8,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << SIZE_LOG2) - ADDR_WIDTH'(1));

    lsu_state_t state, state_next;
    logic       aw_done, aw_done_next;
    logic       w_done, w_done_next;

    logic req_ready_next, resp_valid_next;
    logic awvalid_next, wvalid_next, bready_next, arvalid_next, rready_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    // Return-channel IDs and the low response bit carry no information for a single outstanding beat
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0]};

    // Single-beat, word-sized INCR bursts; the payload comes straight from the request latch
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;

    // Next state plus the next value of every handshake output, so those outputs can be registered
    always_comb begin
        state_next   = state;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_next   = req_we ? WR : AR;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            AR: begin
                if (m_axi_arvalid && m_axi_arready) state_next = R;
            end
            R: begin
                if (m_axi_rvalid && m_axi_rready) state_next = RESP;
            end
            WR: begin
                if (m_axi_awvalid && m_axi_awready) aw_done_next = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_next  = 1'b1;
                if (aw_done_next && w_done_next)    state_next   = B;
            end
            B: begin
                if (m_axi_bvalid && m_axi_bready) state_next = RESP;
            end
            RESP: begin
                if (resp_valid && resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        req_ready_next  = (state_next == IDLE);
        arvalid_next    = (state_next == AR);
        rready_next     = (state_next == R);
        awvalid_next    = (state_next == WR) && !aw_done_next;
        wvalid_next     = (state_next == WR) && !w_done_next;
        bready_next     = (state_next == B);
        resp_valid_next = (state_next == RESP);
    end

    // State, channel-completion flags and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            req_ready     <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            resp_valid    <= 1'b0;
        end else begin
            state         <= state_next;
            aw_done       <= aw_done_next;
            w_done        <= w_done_next;
            req_ready     <= req_ready_next;
            m_axi_arvalid <= arvalid_next;
            m_axi_rready  <= rready_next;
            m_axi_awvalid <= awvalid_next;
            m_axi_wvalid  <= wvalid_next;
            m_axi_bready  <= bready_next;
            resp_valid    <= resp_valid_next;
        end
    end

    // Request payload latch on accept, and response capture from the R or B beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid && req_ready) begin
                addr_q  <= req_addr & ALIGN_MASK;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state == R && m_axi_rvalid && m_axi_rready) begin
                resp_rdata <= m_axi_rdata;
                resp_err   <= m_axi_rresp[1] | ~m_axi_rlast;
            end
            if (state == B && m_axi_bvalid && m_axi_bready) begin
                resp_rdata <= '0;
                resp_err   <= m_axi_bresp[1];
            end
        end
    end

endmodule

// File: tb/tb_axi_lsu_master.sv
// tb_axi_lsu_master: drives the bridge against a configurable AXI RAM stub and
// compares every response with a word-array memory model kept in the bench.
module tb_axi_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic [7:0]  awid, arid, bid, rid;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  awcache, arcache, wstrb;
    logic        awlock, arlock, awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base = 0;

    // Stub slave knobs
    int          aw_delay = 0;
    int          r_delay = 0;
    logic        w_after_aw = 1'b1;
    logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
    logic        rlast_k = 1'b1;

    // Stub slave state and logs
    logic [31:0] smem [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic        aw_have, w_have, r_busy;
    int          aw_wait, r_cnt;
    logic [15:0] aw_addr_q, ar_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    int          aw_count = 0, w_count = 0, b_count = 0, ar_count = 0, r_count = 0;
    logic [15:0] log_awaddr, log_araddr;
    logic [7:0]  log_awlen, log_arlen, log_arid;
    logic [2:0]  log_awsize, log_arsize, log_arprot;
    logic [1:0]  log_awburst, log_arburst;
    logic [3:0]  log_wstrb, log_arcache;
    logic        log_wlast, log_arlock;
    int          proto_err = 0;
    logic        p_aw, p_w, p_ar;
    logic [15:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;

    logic        aw_hs, w_hs, do_write;
    logic [15:0] cur_awaddr;
    logic [31:0] cur_wdata, cur_mask;
    logic [3:0]  cur_wstrb;

    axi_lsu_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub slave ready/response signals, driven from the knobs
    always_comb begin
        awready    = !aw_have && !bvalid && (aw_wait >= aw_delay);
        wready     = !w_have && !bvalid && (!w_after_aw || aw_have);
        arready    = !r_busy;
        bresp      = bresp_k;
        rresp      = rresp_k;
        rlast      = rlast_k;
        bid        = 8'd0;
        rid        = 8'd0;
        aw_hs      = awvalid && awready;
        w_hs       = wvalid && wready;
        do_write   = (aw_have || aw_hs) && (w_have || w_hs);
        cur_awaddr = aw_hs ? awaddr : aw_addr_q;
        cur_wdata  = w_hs ? wdata : w_data_q;
        cur_wstrb  = w_hs ? wstrb : w_strb_q;
        cur_mask   = {{8{cur_wstrb[3]}}, {8{cur_wstrb[2]}}, {8{cur_wstrb[1]}}, {8{cur_wstrb[0]}}};
    end

    // Stub slave: RAM with configurable AW stall and read latency
    always @(posedge clk) begin
        if (!rst_n) begin
            aw_have <= 1'b0; w_have <= 1'b0; r_busy <= 1'b0;
            aw_wait <= 0; r_cnt <= 0; bvalid <= 1'b0; rvalid <= 1'b0;
            rdata <= '0; aw_addr_q <= '0; ar_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            if (aw_hs) begin
                aw_wait <= 0; aw_have <= 1'b1; aw_addr_q <= awaddr; aw_count <= aw_count + 1;
                log_awaddr <= awaddr; log_awlen <= awlen; log_awsize <= awsize; log_awburst <= awburst;
            end
            if (w_hs) begin
                w_have <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_count <= w_count + 1;
                log_wstrb <= wstrb; log_wlast <= wlast;
            end
            if (do_write) begin
                smem[cur_awaddr[15:2]] <= (smem[cur_awaddr[15:2]] & ~cur_mask) | (cur_wdata & cur_mask);
                bvalid <= 1'b1; aw_have <= 1'b0; w_have <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_count <= b_count + 1;
            end
            if (arvalid && arready) begin
                r_busy <= 1'b1; r_cnt <= 0; ar_addr_q <= araddr; ar_count <= ar_count + 1;
                log_araddr <= araddr; log_arlen <= arlen; log_arsize <= arsize; log_arburst <= arburst;
                log_arid <= arid; log_arlock <= arlock; log_arcache <= arcache; log_arprot <= arprot;
            end
            if (r_busy && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid <= 1'b1; rdata <= smem[ar_addr_q[15:2]];
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; r_busy <= 1'b0; r_count <= r_count + 1;
            end
        end
    end

    // Watch for a valid that drops or whose payload moves before its handshake
    always @(posedge clk) begin
        if (!rst_n) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if ((p_aw && (!awvalid || awaddr !== p_awaddr)) ||
                (p_w && (!wvalid || wdata !== p_wdata)) ||
                (p_ar && (!arvalid || araddr !== p_araddr)))
                proto_err <= proto_err + 1;
            p_aw <= awvalid && !awready; p_awaddr <= awaddr;
            p_w  <= wvalid && !wready;   p_wdata  <= wdata;
            p_ar <= arvalid && !arready; p_araddr <= araddr;
        end
    end

    // Reference memory: byte-wise merge of the enabled lanes
    function automatic void ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (!req_ready) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        base = cyc;
    endtask

    task automatic wait_resp(output int lat);
        int n = 0;
        while (!resp_valid && n < 100) begin tick(); n++; end
        if (!resp_valid) begin
            total++; bad++;
            $display("[TB] FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
        end
        lat = cyc - base + 1;
    endtask

    task automatic take_resp(output logic [31:0] rd, output logic er);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er, output int lat, output logic v1);
        start_req(we, a, d, s);
        v1 = we ? (awvalid && wvalid) : arvalid;
        wait_resp(lat);
        take_resp(rd, er);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_axi: got %b required 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b required 0", resp_valid); end
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready: got %b required 0", req_ready); end
        total++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_resp_data: got %h/%b required 0/0", resp_rdata, resp_err);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_read();
        logic [31:0] rd; logic er, v1; int lat;
        smem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        do_req(1'b0, 16'h0040, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (log_araddr !== 16'h0040) begin bad++; $display("[TB] FAIL read_araddr: got %h required 0040", log_araddr); end
        total++;
        if (log_arlen !== 8'd0 || log_arsize !== 3'd2 || log_arburst !== 2'b01) begin
            bad++; $display("[TB] FAIL read_fields: got len %0d size %0d burst %b required 0 2 01", log_arlen, log_arsize, log_arburst);
        end
        total++;
        if (log_arid !== 8'd0 || log_arlock !== 1'b0 || log_arcache !== 4'b0011 || log_arprot !== 3'b000) begin
            bad++; $display("[TB] FAIL read_attr: got id %h lock %b cache %b prot %b", log_arid, log_arlock, log_arcache, log_arprot);
        end
        total++;
        if (v1 !== 1'b1) begin bad++; $display("[TB] FAIL read_arvalid_c1: got %b required 1", v1); end
        total++;
        if (lat !== 4) begin bad++; $display("[TB] FAIL read_latency: got %0d required 4", lat); end
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++; $display("[TB] FAIL read_data: got %h/%b required deadbeef/0", rd, er);
        end
        do_req(1'b0, 16'h0043, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (log_araddr !== 16'h0040 || rd !== ref_mem[16]) begin
            bad++; $display("[TB] FAIL read_unaligned: got addr %h data %h required 0040 %h", log_araddr, rd, ref_mem[16]);
        end
    endtask

    task automatic test_write_strobe();
        logic [31:0] rd; logic er, v1; int lat, w0;
        do_req(1'b1, 16'h0044, 32'h11223344, 4'b0101, rd, er, lat, v1);
        ref_write(16'h0044, 32'h11223344, 4'b0101);
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("[TB] FAIL write_resp: got %h/%b required 0/0", rd, er); end
        total++;
        if (lat !== 4 || v1 !== 1'b1) begin bad++; $display("[TB] FAIL write_timing: got lat %0d v1 %b required 4 1", lat, v1); end
        total++;
        if (log_awaddr !== 16'h0044 || log_wstrb !== 4'b0101 || log_wlast !== 1'b1) begin
            bad++; $display("[TB] FAIL write_fields: got %h %b %b required 0044 0101 1", log_awaddr, log_wstrb, log_wlast);
        end
        total++;
        if (log_awlen !== 8'd0 || log_awsize !== 3'd2 || log_awburst !== 2'b01) begin
            bad++; $display("[TB] FAIL write_burst: got %0d %0d %b required 0 2 01", log_awlen, log_awsize, log_awburst);
        end
        do_req(1'b0, 16'h0044, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (rd !== 32'h00220044 || er !== 1'b0) begin
            bad++; $display("[TB] FAIL strobe_readback: got %h/%b required 00220044/0", rd, er);
        end
        w0 = w_count;
        do_req(1'b1, 16'h0044, 32'hFFFFFFFF, 4'b0000, rd, er, lat, v1);
        total++;
        if (w_count !== w0 + 1) begin bad++; $display("[TB] FAIL zero_strobe_issued: got %0d required %0d", w_count, w0 + 1); end
        do_req(1'b0, 16'h0044, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (rd !== ref_mem[17]) begin bad++; $display("[TB] FAIL zero_strobe_readback: got %h required %h", rd, ref_mem[17]); end
    endtask

    task automatic test_aw_delay();
        logic [31:0] rd; logic er, v1; int lat, aw0, w0, b0;
        aw_delay = 3; w_after_aw = 1'b0;
        aw0 = aw_count; w0 = w_count; b0 = b_count;
        start_req(1'b1, 16'h0080, 32'hCAFEF00D, 4'hF);
        ref_write(16'h0080, 32'hCAFEF00D, 4'hF);
        total++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin bad++; $display("[TB] FAIL awdelay_c1: got %b%b required 11", awvalid, wvalid); end
        tick();
        total++;
        if (wvalid !== 1'b0 || w_count !== w0 + 1) begin
            bad++; $display("[TB] FAIL awdelay_w_first: got wvalid %b wcount %0d required 0 %0d", wvalid, w_count, w0 + 1);
        end
        total++;
        if (awvalid !== 1'b1 || awaddr !== 16'h0080 || aw_count !== aw0) begin
            bad++; $display("[TB] FAIL awdelay_aw_hold: got %b %h %0d required 1 0080 %0d", awvalid, awaddr, aw_count, aw0);
        end
        tick();
        total++;
        if (awvalid !== 1'b1 || awaddr !== 16'h0080) begin bad++; $display("[TB] FAIL awdelay_aw_hold2: got %b %h", awvalid, awaddr); end
        wait_resp(lat);
        take_resp(rd, er);
        repeat (3) tick();
        total++;
        if (b_count !== b0 + 1 || aw_count !== aw0 + 1 || w_count !== w0 + 1) begin
            bad++; $display("[TB] FAIL awdelay_counts: got b %0d aw %0d w %0d required %0d %0d %0d", b_count, aw_count, w_count, b0 + 1, aw0 + 1, w0 + 1);
        end
        total++;
        if (er !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL awdelay_resp: got err %b extra %b required 0 0", er, resp_valid); end
        aw_delay = 0; w_after_aw = 1'b1;
        do_req(1'b0, 16'h0080, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (rd !== ref_mem[32]) begin bad++; $display("[TB] FAIL awdelay_readback: got %h required %h", rd, ref_mem[32]); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, v1; int lat;
        bresp_k = 2'b10;
        do_req(1'b1, 16'h0090, 32'h12345678, 4'hF, rd, er, lat, v1);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL err_slverr_write: got %b/%h required 1/0", er, rd); end
        bresp_k = 2'b00; rresp_k = 2'b11;
        do_req(1'b0, 16'h0040, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (er !== 1'b1) begin bad++; $display("[TB] FAIL err_decerr_read: got %b required 1", er); end
        rresp_k = 2'b00; rlast_k = 1'b0;
        do_req(1'b0, 16'h0040, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (er !== 1'b1) begin bad++; $display("[TB] FAIL err_no_rlast: got %b required 1", er); end
        rlast_k = 1'b1; rresp_k = 2'b01;
        do_req(1'b0, 16'h0040, 32'h0, 4'h0, rd, er, lat, v1);
        total++;
        if (er !== 1'b0 || rd !== ref_mem[16]) begin bad++; $display("[TB] FAIL err_exokay: got %b/%h required 0/%h", er, rd, ref_mem[16]); end
        rresp_k = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat, ar0;
        start_req(1'b0, 16'h0040, 32'h0, 4'h0);
        wait_resp(lat);
        ar0 = ar_count;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== ref_mem[16] || resp_err !== 1'b0) begin
                bad++; $display("[TB] FAIL stall_hold%0d: got %b %h %b required 1 %h 0", i, resp_valid, resp_rdata, resp_err, ref_mem[16]);
            end
            total++;
            if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_req_ready%0d: got %b required 0", i, req_ready); end
        end
        req_valid = 1'b0;
        total++;
        if (ar_count !== ar0) begin bad++; $display("[TB] FAIL stall_no_accept: got %0d required %0d", ar_count, ar0); end
        take_resp(rd, er);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        r_delay = 6;
        start_req(1'b0, 16'h0040, 32'h0, 4'h0);
        while (!rready && n < 10) begin tick(); n++; end
        total++;
        if (rready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_reach_r: got %b required 1", rready); end
        rst_n = 1'b0;
        tick();
        total++;
        if (rready !== 1'b0 || resp_valid !== 1'b0 || arvalid !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_clear: got rready %b resp_valid %b arvalid %b required 000", rready, resp_valid, arvalid);
        end
        rst_n = 1'b1; r_delay = 0;
        tick();
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_idle: got %b required 1", req_ready); end
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        total++;
        if (seen !== 0) begin bad++; $display("[TB] FAIL midreset_no_resp: got %0d responses required 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d, exp_rd; logic er, v1, we; logic [3:0] s; logic [15:0] a; int lat, word;
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            word = 64 + int'($urandom_range(0, 15));
            a    = 16'(word * 4 + int'($urandom_range(0, 3)));
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            exp_rd = we ? 32'h0 : ref_mem[word];
            if (we) ref_write(a, d, s);
            start_req(we, a, d, s);
            v1 = we ? (awvalid && wvalid) : arvalid;
            wait_resp(lat);
            repeat ($urandom_range(0, 2)) tick();
            take_resp(rd, er);
            total++;
            if (rd !== exp_rd || er !== 1'b0) begin
                bad++; $display("[TB] FAIL b2b_data%0d: got %h/%b required %h/0 (we=%b addr=%h)", i, rd, er, exp_rd, we, a);
            end
            total++;
            if (lat !== 4 || v1 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_timing%0d: got lat %0d v1 %b required 4 1", i, lat, v1); end
            total++;
            if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready%0d: got %b required 1", i, req_ready); end
        end
    endtask

    task automatic test_protocol();
        total++;
        if (proto_err !== 0) begin bad++; $display("[TB] FAIL valid_stability: got %0d violations required 0", proto_err); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            smem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_read();
        test_write_strobe();
        test_aw_delay();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
